branch_cond_unit: RTL and testbench

Parametrised branch-condition unit for the ID stage of the pipelined MIPS core. It generalises the single bgez AND-gating into a full resolver covering all conditional branch kinds. It waits for operand readiness and stalls the front end while operands are pending, then registers a taken/not-taken decision, target address and link request for the PC-select logic. The delay-slot instruction is always executed; the unit never flushes it.

---
 rtl/branch_cond_unit_pkg.sv | 25 ++
 rtl/branch_cond_unit_if.sv | 34 +++
 rtl/branch_cond_unit_eval.sv | 42 ++++
 rtl/branch_cond_unit.sv | 153 +++++++++++++++
 tb/tb_branch_cond_unit.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_cond_unit_pkg.sv
// Shared types for the ID-stage branch-condition unit: branch kinds,
// FSM states and the link register index used by the AL variants.
package branch_pkg;

    // Encodings 8..15 are unused and resolve not-taken without link.
    typedef enum logic [3:0] {
        BEQ    = 4'd0,
        BNE    = 4'd1,
        BGEZ   = 4'd2,
        BGTZ   = 4'd3,
        BLEZ   = 4'd4,
        BLTZ   = 4'd5,
        BGEZAL = 4'd6,
        BLTZAL = 4'd7
    } br_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } br_state_t;

    // Register written with pc_plus4 + 4 when res_link is set.
    localparam int unsigned LINK_REG = 31;

endpackage

// File: rtl/branch_cond_unit_if.sv
// Bus between the ID stage and the branch-condition unit.
// master = ID/hazard side, slave = branch_cond_unit.
interface branch_cond_unit_if #(
    parameter int WIDTH  = 32,
    parameter int STAT_W = 32
) ();
    import branch_pkg::*;

    logic              br_valid;
    br_op_t            br_op;
    logic [WIDTH-1:0]  rs_val;
    logic [WIDTH-1:0]  rt_val;
    logic              ops_ready;
    logic [WIDTH-1:0]  pc_plus4;
    logic [15:0]       imm16;
    logic              flush;
    logic              stall;
    logic              res_valid;
    logic              res_taken;
    logic [WIDTH-1:0]  res_target;
    logic              res_link;
    logic [STAT_W-1:0] stat_total;
    logic [STAT_W-1:0] stat_taken;

    modport master (
        output br_valid, br_op, rs_val, rt_val, ops_ready, pc_plus4, imm16, flush,
        input  stall, res_valid, res_taken, res_target, res_link, stat_total, stat_taken
    );

    modport slave (
        input  br_valid, br_op, rs_val, rt_val, ops_ready, pc_plus4, imm16, flush,
        output stall, res_valid, res_taken, res_target, res_link, stat_total, stat_taken
    );
endinterface

// File: rtl/branch_cond_unit_eval.sv
// Combinational branch-condition evaluator: decides taken/link from the
// branch kind and the (forwarded) rs/rt operands.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  br_op_t           op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic             taken_o,
    output logic             link_o
);
    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs_i[WIDTH-1];
    assign rs_zero = (rs_i == '0);

    // Condition decode; unknown kinds fall through to not-taken, no link.
    always_comb begin
        taken_o = 1'b0;
        link_o  = 1'b0;
        case (op_i)
            BEQ:    taken_o = (rs_i == rt_i);
            BNE:    taken_o = (rs_i != rt_i);
            BGEZ:   taken_o = !rs_neg;
            BGTZ:   taken_o = !rs_neg && !rs_zero;
            BLEZ:   taken_o = rs_neg || rs_zero;
            BLTZ:   taken_o = rs_neg;
            BGEZAL: begin
                taken_o = !rs_neg;
                link_o  = 1'b1;
            end
            BLTZAL: begin
                taken_o = rs_neg;
                link_o  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/branch_cond_unit.sv
// ID-stage branch resolver. Stalls IF/ID while operands are pending,
// then registers taken/target/link for the PC-select logic.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
//
// state | meaning
// IDLE  | no branch pending; a ready branch is resolved directly
// WAIT  | branch op/pc/imm captured, waiting for ops_ready
module branch_cond_unit
    import branch_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_cond_unit_if.slave  bus
);
    br_state_t        state_q, state_d;
    br_op_t           op_q;
    logic [WIDTH-1:0] pc_q;
    logic [15:0]      imm_q;

    logic             eval_en;
    logic             capture;
    logic             stall_d;
    br_op_t           eval_op;
    logic [WIDTH-1:0] eval_pc;
    logic [15:0]      eval_imm;
    logic [WIDTH-1:0] eval_target;
    logic             eval_taken;
    logic             eval_link;

    logic             res_valid_q;
    logic             res_taken_q;
    logic             res_link_q;
    logic [WIDTH-1:0] res_target_q;

    // In WAIT the live bus fields may already belong to the next instruction,
    // so the captured copies are used instead.
    assign eval_op     = (state_q == WAIT) ? op_q  : bus.br_op;
    assign eval_pc     = (state_q == WAIT) ? pc_q  : bus.pc_plus4;
    assign eval_imm    = (state_q == WAIT) ? imm_q : bus.imm16;
    assign eval_target = eval_pc + {{(WIDTH-18){eval_imm[15]}}, eval_imm, 2'b00};

    branch_cond_eval #(.WIDTH(WIDTH)) u_eval (
        .op_i    (eval_op),
        .rs_i    (bus.rs_val),
        .rt_i    (bus.rt_val),
        .taken_o (eval_taken),
        .link_o  (eval_link)
    );

    // Next state, stall and evaluate/capture strobes; flush overrides all.
    always_comb begin
        state_d = state_q;
        eval_en = 1'b0;
        capture = 1'b0;
        stall_d = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.br_valid) begin
                        if (bus.ops_ready) begin
                            eval_en = 1'b1;
                        end else begin
                            capture = 1'b1;
                            stall_d = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.ops_ready) begin
                        eval_en = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stall_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.stall = stall_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture the branch fields when entering WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= BEQ;
            pc_q  <= '0;
            imm_q <= '0;
        end else if (capture) begin
            op_q  <= bus.br_op;
            pc_q  <= bus.pc_plus4;
            imm_q <= bus.imm16;
        end
    end

    // Result registers: valid pulses for one cycle, fields hold until next resolution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_taken_q  <= 1'b0;
            res_link_q   <= 1'b0;
            res_target_q <= '0;
        end else begin
            res_valid_q <= eval_en;
            if (eval_en) begin
                res_taken_q  <= eval_taken;
                res_link_q   <= eval_link;
                res_target_q <= eval_target;
            end
        end
    end

    assign bus.res_valid  = res_valid_q;
    assign bus.res_taken  = res_taken_q;
    assign bus.res_link   = res_link_q;
    assign bus.res_target = res_target_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_total_q;
    logic [STAT_W-1:0] stat_taken_q;

    // Saturating counters driven by the registered result pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total_q <= '0;
            stat_taken_q <= '0;
        end else if (res_valid_q) begin
            if (stat_total_q != '1)
                stat_total_q <= stat_total_q + STAT_W'(1);
            if (res_taken_q && (stat_taken_q != '1))
                stat_taken_q <= stat_taken_q + STAT_W'(1);
        end
    end

    assign bus.stat_total = stat_total_q;
    assign bus.stat_taken = stat_taken_q;
`else
    assign bus.stat_total = '0;
    assign bus.stat_taken = '0;
`endif
endmodule

// File: tb/tb_branch_cond_unit.sv
module tb_branch_cond_unit;
    import branch_pkg::*;

    localparam int W  = 32;
    localparam int SW = 4;
    localparam int SAT = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_cond_unit_if #(.WIDTH(W), .STAT_W(SW)) bus ();

    branch_cond_unit #(.WIDTH(W), .STAT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_total = 0;
    int exp_taken = 0;

    // Reference model straight from the branch rules, using signed arithmetic.
    function automatic bit m_taken(int op, logic [31:0] rs, logic [31:0] rt);
        int s;
        s = $signed(rs);
        case (op)
            0:       return rs == rt;
            1:       return rs != rt;
            2, 6:    return s >= 0;
            3:       return s > 0;
            4:       return s <= 0;
            5, 7:    return s < 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_link(int op);
        return (op == 6) || (op == 7);
    endfunction

    function automatic logic [31:0] m_target(logic [31:0] pc, logic [15:0] imm);
        int off;
        off = $signed(imm) * 4;
        return pc + off;
    endfunction

    function automatic int stat_view(int v);
`ifdef BRANCH_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic model_count(bit tkn);
        if (exp_total < SAT) exp_total++;
        if (tkn && exp_taken < SAT) exp_taken++;
    endtask

    task automatic drive_idle();
        bus.br_valid  = 1'b0;
        bus.ops_ready = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.br_op = BEQ; bus.rs_val = '0; bus.rt_val = '0; bus.pc_plus4 = '0; bus.imm16 = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.res_valid); end
        checks++; if (bus.res_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", bus.res_taken); end
        checks++; if (bus.res_link !== 1'b0) begin errors++; $display("FAIL reset_link got %b exp 0", bus.res_link); end
        checks++; if (bus.res_target !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp 0", bus.res_target); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
        checks++; if (bus.stat_total !== 4'h0) begin errors++; $display("FAIL reset_stat_total got %h exp 0", bus.stat_total); end
        checks++; if (bus.stat_taken !== 4'h0) begin errors++; $display("FAIL reset_stat_taken got %h exp 0", bus.stat_taken); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_total = 0;
        exp_taken = 0;
    endtask

    task automatic test_directed();
        // BEQ taken, then hold check
        @(negedge clk);
        bus.br_valid = 1'b1; bus.ops_ready = 1'b1; bus.br_op = BEQ;
        bus.rs_val = 32'h1234; bus.rt_val = 32'h1234; bus.pc_plus4 = 32'h0000_3004; bus.imm16 = 16'h0003;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL beq_stall got %b exp 0", bus.stall); end
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL beq_valid got %b exp 1", bus.res_valid); end
        checks++; if (bus.res_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", bus.res_taken); end
        checks++; if (bus.res_target !== 32'h0000_3010) begin errors++; $display("FAIL beq_target got %h exp 00003010", bus.res_target); end
        checks++; if (bus.res_link !== 1'b0) begin errors++; $display("FAIL beq_link got %b exp 0", bus.res_link); end
        model_count(1'b1);
        @(negedge clk);
        drive_idle();
        bus.rs_val = 32'h1; bus.pc_plus4 = 32'hDEAD_0000;
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got %b exp 0", bus.res_valid); end
        checks++; if (bus.res_taken !== 1'b1) begin errors++; $display("FAIL hold_taken got %b exp 1", bus.res_taken); end
        checks++; if (bus.res_target !== 32'h0000_3010) begin errors++; $display("FAIL hold_target got %h exp 00003010", bus.res_target); end

        // BGEZAL with negative rs: not taken, link set, backward target
        @(negedge clk);
        bus.br_valid = 1'b1; bus.ops_ready = 1'b1; bus.br_op = BGEZAL;
        bus.rs_val = 32'h8000_0000; bus.rt_val = 32'h0; bus.pc_plus4 = 32'h0040_0100; bus.imm16 = 16'hFFFF;
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bgezal_valid got %b exp 1", bus.res_valid); end
        checks++; if (bus.res_taken !== 1'b0) begin errors++; $display("FAIL bgezal_taken got %b exp 0", bus.res_taken); end
        checks++; if (bus.res_link !== 1'b1) begin errors++; $display("FAIL bgezal_link got %b exp 1", bus.res_link); end
        checks++; if (bus.res_target !== 32'h0040_00FC) begin errors++; $display("FAIL bgezal_target got %h exp 004000fc", bus.res_target); end
        model_count(1'b0);

        // Target wrap-around
        @(negedge clk);
        bus.br_op = BNE; bus.rs_val = 32'h5; bus.rt_val = 32'h7;
        bus.pc_plus4 = 32'hFFFF_FFFC; bus.imm16 = 16'h0002;
        @(posedge clk); #1;
        checks++; if (bus.res_taken !== 1'b1) begin errors++; $display("FAIL wrap_taken got %b exp 1", bus.res_taken); end
        checks++; if (bus.res_target !== 32'h0000_0004) begin errors++; $display("FAIL wrap_target got %h exp 00000004", bus.res_target); end
        checks++; if (bus.res_link !== 1'b0) begin errors++; $display("FAIL wrap_link got %b exp 0", bus.res_link); end
        model_count(1'b1);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_wait_bgtz();
        @(negedge clk);
        bus.br_valid = 1'b1; bus.ops_ready = 1'b0; bus.br_op = BGTZ;
        bus.rs_val = 32'h0; bus.rt_val = 32'h0; bus.pc_plus4 = 32'h0000_1000; bus.imm16 = 16'h0010;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                @(negedge clk);
                // live fields change while waiting; the captured ones must be used
                bus.br_valid = c[0]; bus.br_op = BEQ;
                bus.pc_plus4 = 32'h7777_0000 + c; bus.imm16 = 16'h8000;
            end
            #1;
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL wait_stall cycle %0d got %b exp 1", c, bus.stall); end
            @(posedge clk); #1;
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL wait_valid cycle %0d got %b exp 0", c, bus.res_valid); end
        end
        @(negedge clk);
        bus.ops_ready = 1'b1; bus.rs_val = 32'h0000_0001;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL wait_ready_stall got %b exp 0", bus.stall); end
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL wait_res_valid got %b exp 1", bus.res_valid); end
        checks++; if (bus.res_taken !== 1'b1) begin errors++; $display("FAIL wait_taken got %b exp 1", bus.res_taken); end
        checks++; if (bus.res_target !== 32'h0000_1040) begin errors++; $display("FAIL wait_target got %h exp 00001040", bus.res_target); end
        model_count(1'b1);
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL wait_pulse_len got %b exp 0", bus.res_valid); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.br_valid = 1'b1; bus.ops_ready = 1'b0; bus.br_op = BLEZ;
        bus.rs_val = 32'h0; bus.pc_plus4 = 32'h0000_2000; bus.imm16 = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        bus.br_valid = 1'b0; bus.flush = 1'b1; bus.ops_ready = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_wait_stall got %b exp 0", bus.stall); end
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_valid got %b exp 0", bus.res_valid); end
        @(negedge clk);
        bus.flush = 1'b0; bus.ops_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_after got %b exp 0", bus.res_valid); end
        // flush in IDLE with a ready branch suppresses evaluation
        @(negedge clk);
        bus.br_valid = 1'b1; bus.ops_ready = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_valid got %b exp 0", bus.res_valid); end
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        checks++; if (bus.stat_total !== SW'(stat_view(exp_total))) begin errors++; $display("FAIL flush_stat_total got %0d exp %0d", bus.stat_total, stat_view(exp_total)); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int op;
            int nwait;
            logic [31:0] rs, rt, pc;
            logic [15:0] imm;
            bit et, el;
            logic [31:0] eg;
            op = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: rs = 32'h0;
                1: rs = 32'h8000_0000 | $urandom;
                default: rs = $urandom;
            endcase
            rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            imm = 16'($urandom);
            nwait = $urandom_range(0, 2);
            et = m_taken(op, rs, rt);
            el = m_link(op);
            eg = m_target(pc, imm);
            @(negedge clk);
            bus.br_valid = 1'b1; bus.br_op = br_op_t'(op[3:0]);
            bus.pc_plus4 = pc; bus.imm16 = imm;
            bus.rs_val = $urandom; bus.rt_val = $urandom;
            bus.ops_ready = (nwait == 0);
            for (int c = 0; c < nwait; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rand_stall iter %0d got %b exp 1", n, bus.stall); end
                @(posedge clk);
            end
            if (nwait > 0) begin
                @(negedge clk);
                bus.br_valid = 1'b0; bus.pc_plus4 = $urandom; bus.imm16 = 16'($urandom);
                bus.ops_ready = 1'b1;
            end
            bus.rs_val = rs; bus.rt_val = rt;
            #1;
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rand_ready_stall iter %0d got %b exp 0", n, bus.stall); end
            @(posedge clk); #1;
            checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL rand_valid iter %0d got %b exp 1", n, bus.res_valid); end
            checks++; if (bus.res_taken !== et) begin errors++; $display("FAIL rand_taken iter %0d op %0d rs %h rt %h got %b exp %b", n, op, rs, rt, bus.res_taken, et); end
            checks++; if (bus.res_link !== el) begin errors++; $display("FAIL rand_link iter %0d op %0d got %b exp %b", n, op, bus.res_link, el); end
            if (op < 8) begin
                checks++; if (bus.res_target !== eg) begin errors++; $display("FAIL rand_target iter %0d got %h exp %h", n, bus.res_target, eg); end
            end
            model_count(et);
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        checks++; if (bus.stat_total !== SW'(stat_view(exp_total))) begin errors++; $display("FAIL rand_stat_total got %0d exp %0d", bus.stat_total, stat_view(exp_total)); end
        checks++; if (bus.stat_taken !== SW'(stat_view(exp_taken))) begin errors++; $display("FAIL rand_stat_taken got %0d exp %0d", bus.stat_taken, stat_view(exp_taken)); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        bus.br_valid = 1'b1; bus.ops_ready = 1'b0; bus.br_op = BGEZ;
        bus.rs_val = 32'h0; bus.pc_plus4 = 32'h0000_5000; bus.imm16 = 16'h0004;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstwait_stall got %b exp 0", bus.stall); end
        checks++; if (bus.stat_total !== 4'h0) begin errors++; $display("FAIL rstwait_stat got %h exp 0", bus.stat_total); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.ops_ready = 1'b1;
        exp_total = 0;
        exp_taken = 0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstwait_rel_stall got %b exp 0", bus.stall); end
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstwait_valid got %b exp 0", bus.res_valid); end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 17; n++) begin
            logic [31:0] v, pc;
            logic [15:0] imm;
            v = $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            imm = 16'($urandom);
            @(negedge clk);
            bus.br_valid = 1'b1; bus.ops_ready = 1'b1; bus.br_op = BEQ;
            bus.rs_val = v; bus.rt_val = v; bus.pc_plus4 = pc; bus.imm16 = imm;
            @(posedge clk); #1;
            checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid iter %0d got %b exp 1", n, bus.res_valid); end
            checks++; if (bus.res_target !== m_target(pc, imm)) begin errors++; $display("FAIL b2b_target iter %0d got %h exp %h", n, bus.res_target, m_target(pc, imm)); end
            model_count(1'b1);
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        checks++; if (bus.stat_total !== SW'(stat_view(SAT))) begin errors++; $display("FAIL sat_stat_total got %0d exp %0d", bus.stat_total, stat_view(SAT)); end
        checks++; if (bus.stat_taken !== SW'(stat_view(exp_taken))) begin errors++; $display("FAIL sat_stat_taken got %0d exp %0d", bus.stat_taken, stat_view(exp_taken)); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_wait_bgtz();
        test_flush();
        test_random();
        test_reset_mid_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
